flags_bank_reg: RTL
===================

// Module: flags_bank_reg
// PURPOSE
//  Multi-bank over/underflow flag register for the matmul result path: one MAX_DIM^2-bit
//  flag word per result bank, one bit per matrix element. Supports overwrite or sticky
//  accumulate, bus-side write-1-to-clear, registered read with bit count, per-bank summary.
//  Sits between the matmul flag outputs and the register/bus read mux.
// PARAMETERS
//  DATA_WIDTH  32  element width in bits
//  BUS_WIDTH   64  bus width in bits
//  MAX_DIM     BUS_WIDTH/DATA_WIDTH  matrix dimension (derived); FW = MAX_DIM*MAX_DIM flag bits
//  NUM_BANKS   4   number of flag words (>=1, need not be a power of 2)
//  BANK_W      $clog2(NUM_BANKS) (min 1)  bank index width; CW = $clog2(FW+1) count width
// PORTS
//  clk_i        in   1       clock, all logic on rising edge
//  rst_i        in   1       synchronous reset, active-high
//  wr_en_i      in   1       matmul flag write strobe
//  wr_bank_i    in   BANK_W  target bank for write
//  wr_data_i    in   FW      flag bits from matmul
//  sticky_i     in   1       1: OR into bank; 0: overwrite bank
//  clr_en_i     in   1       bus clear strobe (write-1-to-clear)
//  clr_bank_i   in   BANK_W  target bank for clear
//  clr_mask_i   in   FW      1 = clear that bit
//  rd_en_i      in   1       read request
//  rd_bank_i    in   BANK_W  bank to read
//  rd_data_o    out  FW      registered read data
//  rd_cnt_o     out  CW      number of 1s in rd_data_o
//  rd_valid_o   out  1       1-cycle pulse: rd_data_o/rd_cnt_o valid
//  any_flag_o   out  NUM_BANKS  bit b = OR of bank b, registered
//  new_flag_o   out  1       1-cycle pulse: a write set a bit that was 0
// BEHAVIOUR
//  - Reset (rst_i=1 at edge): all banks 0, rd_data_o=0, rd_cnt_o=0, rd_valid_o=0,
//    any_flag_o=0, new_flag_o=0. Reset dominates all strobes in that cycle; in-flight read dropped.
//  - Bank update at edge, per bank b (old = current contents):
//      W = wr_en_i & wr_bank_i==b;  C = clr_en_i & clr_bank_i==b
//      sticky_i=1: next = (old & ~(C?clr_mask_i:0)) | (W?wr_data_i:0)
//      sticky_i=0 & W: next = wr_data_i (clear on same bank that cycle ignored)
//      only C: next = old & ~clr_mask_i;  neither: hold
//    i.e. same-cycle write beats clear on any overlapping bit.
//  - Bank index >= NUM_BANKS on wr/clr: no bank changes, no new_flag_o. On rd: returns
//    rd_data_o=0, rd_cnt_o=0, rd_valid_o still pulses.
//  - Read: rd_en_i sampled at edge N -> rd_data_o/rd_cnt_o/rd_valid_o from edge N, visible
//    cycle N+1; returns contents BEFORE any same-cycle write/clear (old value). rd_data_o and
//    rd_cnt_o hold until next read or reset; rd_valid_o low when no read. Back-to-back reads
//    every cycle allowed.
//  - rd_cnt_o: popcount of the captured word, range 0..FW, no saturation needed.
//  - new_flag_o: registered, high in cycle after a write where (wr_data_i & ~old) != 0 for the
//    addressed bank, regardless of sticky_i.
//  - any_flag_o: registered OR of each bank's NEXT value, so it tracks banks with 1-cycle
//    latency after the update edge, same as bank contents.
//  - No handshake back-pressure: every strobe is accepted the cycle it is asserted.
// TESTING (MAX_DIM=2, FW=4, NUM_BANKS=4)
//  1 rst_i 1 cycle, then rd_en bank0..3 -> rd_data_o=4'h0, cnt 0, any_flag_o=4'b0000 each read.
//  2 wr bank1 data 4'b0101 sticky=1, next wr 4'b0011 sticky=1, rd bank1 -> 4'b0111, cnt 3,
//    any_flag_o=4'b0010; new_flag_o pulses after both writes.
//  3 bank1=4'b0111, wr 4'b1000 sticky=0 -> rd 4'b1000, cnt 1; rewrite 4'b1000 sticky=1 ->
//    new_flag_o stays 0.
//  4 bank2=4'b1111; same cycle clr bank2 mask 4'b1111 + wr bank2 4'b0001 sticky=1 ->
//    bank2=4'b0001; rd_en in that same cycle returns 4'b1111.
//  5 NUM_BANKS=3: wr bank3 4'b1111 -> no change, any_flag_o unchanged, no new_flag_o;
//    rd bank3 -> 0, cnt 0, rd_valid_o=1.
//  6 banks loaded, rd_en held, rst_i asserted mid-burst -> next cycle rd_valid_o=0, all outputs
//    0; post-reset rd bank1 -> 4'b0000.

Source files
------------

// File: rtl/flags_bank_reg.sv
// ============================================================================
//  Module      : flags_bank_reg
//  Description : Multi-bank over/underflow flag register for the matmul result
//                path: sticky/overwrite update, write-1-to-clear, registered
//                read with popcount and per-bank any-flag summary.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module flags_bank_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 64,
    parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    parameter int NUM_BANKS  = 4,
    parameter int FW         = MAX_DIM * MAX_DIM,
    parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    parameter int CW         = $clog2(FW + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [BANK_W-1:0]    wr_bank_i,
    input  logic [FW-1:0]        wr_data_i,
    input  logic                 sticky_i,
    input  logic                 clr_en_i,
    input  logic [BANK_W-1:0]    clr_bank_i,
    input  logic [FW-1:0]        clr_mask_i,
    input  logic                 rd_en_i,
    input  logic [BANK_W-1:0]    rd_bank_i,
    output logic [FW-1:0]        rd_data_o,
    output logic [CW-1:0]        rd_cnt_o,
    output logic                 rd_valid_o,
    output logic [NUM_BANKS-1:0] any_flag_o,
    output logic                 new_flag_o
);

    logic [FW-1:0]        bank_q [NUM_BANKS];
    logic [FW-1:0]        bank_d [NUM_BANKS];
    logic [NUM_BANKS-1:0] wr_sel;
    logic [NUM_BANKS-1:0] clr_sel;
    logic [FW-1:0]        rd_word;
    logic [CW-1:0]        rd_ones;

    logic [FW-1:0]        rd_data_q,  rd_data_d;
    logic [CW-1:0]        rd_cnt_q,   rd_cnt_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [NUM_BANKS-1:0] any_flag_q, any_flag_d;
    logic                 new_flag_q, new_flag_d;

    // Out-of-range bank indices match no decoder output, so they are ignored.
    always_comb begin
        wr_sel  = '0;
        clr_sel = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            wr_sel[b]  = wr_en_i  && (wr_bank_i  == BANK_W'(b));
            clr_sel[b] = clr_en_i && (clr_bank_i == BANK_W'(b));
        end
    end

    // Write wins over a same-cycle clear on every overlapping bit.
    always_comb begin
        new_flag_d = 1'b0;
        any_flag_d = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_d[b] = bank_q[b];
            if (sticky_i) begin
                bank_d[b] = (bank_q[b] & ~(clr_sel[b] ? clr_mask_i : '0))
                          | (wr_sel[b] ? wr_data_i : '0);
            end else if (wr_sel[b]) begin
                bank_d[b] = wr_data_i;
            end else if (clr_sel[b]) begin
                bank_d[b] = bank_q[b] & ~clr_mask_i;
            end
            if (wr_sel[b] && |(wr_data_i & ~bank_q[b])) begin
                new_flag_d = 1'b1;
            end
            any_flag_d[b] = |bank_d[b];
        end
    end

    // Read path samples the pre-update contents.
    always_comb begin
        rd_word = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rd_bank_i == BANK_W'(b)) begin
                rd_word = bank_q[b];
            end
        end
        rd_ones = '0;
        for (int i = 0; i < FW; i++) begin
            rd_ones = rd_ones + CW'(rd_word[i]);
        end
        rd_valid_d = rd_en_i;
        rd_data_d  = rd_en_i ? rd_word : rd_data_q;
        rd_cnt_d   = rd_en_i ? rd_ones : rd_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_q[b] <= '0;
            end
            rd_data_q  <= '0;
            rd_cnt_q   <= '0;
            rd_valid_q <= 1'b0;
            any_flag_q <= '0;
            new_flag_q <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_q[b] <= bank_d[b];
            end
            rd_data_q  <= rd_data_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_valid_q <= rd_valid_d;
            any_flag_q <= any_flag_d;
            new_flag_q <= new_flag_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_cnt_o   = rd_cnt_q;
    assign rd_valid_o = rd_valid_q;
    assign any_flag_o = any_flag_q;
    assign new_flag_o = new_flag_q;

endmodule

`default_nettype wire
